// File: rtl/blink_period_meter.sv
// blink_period_meter
//
// Receive-side companion of the LED blinker. Samples an asynchronous square wave,
// measures the number of CLOCK_50 cycles between consecutive toggles (the half-period),
// reports lock when two consecutive measurements fall within EXPECTED +/- TOL, and
// flags loss of activity after TIMEOUT cycles without a toggle.
//
// Ports:
//   CLOCK_50      in   sole clock
//   RESET         in   asynchronous, active-high reset
//   SIG_IN        in   asynchronous square-wave input
//   PERIOD        out  last measured half-period in cycles (CNT_W bits)
//   PERIOD_VALID  out  one-cycle pulse when PERIOD updates
//   LOCKED        out  two consecutive half-periods within EXPECTED +/- TOL
//   TIMEOUT_FLAG  out  no toggle seen for TIMEOUT cycles
//   LED           out  LED[0] = LOCKED, LED[1] = TIMEOUT_FLAG
//
// Build option:
//   GLITCH_FILTER_EN  when defined, the synchronized input only changes level after the
//                     new value has been stable for FILTER_LEN cycles, so pulses shorter
//                     than FILTER_LEN are ignored. Undefined (default): no filter.

module blink_period_meter #(
  parameter int unsigned CNT_W       = 33,
  parameter int unsigned EXPECTED    = 50000000,
  parameter int unsigned TOL         = 1000,
  parameter int unsigned TIMEOUT     = 100000000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             SIG_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             LOCKED,
  output logic             TIMEOUT_FLAG,
  output logic [1:0]       LED
);

  // Elaboration-time sanity checks on the configuration.
  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || (64'(TIMEOUT) >> CNT_W) != 64'd0) begin : g_param_check
    $error("blink_period_meter: illegal parameter combination");
  end

  localparam int unsigned MeasW = CNT_W + 1;
  localparam int unsigned WideW = CNT_W + 2;

  localparam logic [CNT_W:0]   TimeoutW = MeasW'(TIMEOUT);
  localparam logic [CNT_W+1:0] ExpW     = WideW'(EXPECTED);
  localparam logic [CNT_W+1:0] TolW     = WideW'(TOL);

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StTimedOut
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;
  logic                   in_tol_prev_q, in_tol_prev_d;

  logic             sync_lvl;
  logic             lvl;
  logic             edge_det;
  logic [CNT_W:0]   meas;
  logic [CNT_W+1:0] meas_w;
  logic             in_tol;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], SIG_IN};
  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             filt_q, filt_d;
  logic [FiltW-1:0] stab_q, stab_d;

  // stab_q counts how many cycles the synchronized level has disagreed with the
  // filtered level; the filtered level follows once the disagreement persists.
  always_comb begin
    filt_d = filt_q;
    stab_d = '0;
    if (sync_lvl != filt_q) begin
      if (stab_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d = sync_lvl;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else begin
      filt_q <= filt_d;
      stab_q <= stab_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_lvl;
`endif

  // Either polarity counts as an edge.
  assign edge_det = (lvl != hist_q);
  assign hist_d   = lvl;

  // Measured interval is cnt+1; widened twice so neither the +1 nor the tolerance
  // window arithmetic can wrap.
  assign meas   = {1'b0, cnt_q} + 1'b1;
  assign meas_w = {1'b0, meas};
  assign in_tol = ((meas_w + TolW) >= ExpW) && (meas_w <= (ExpW + TolW));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_d      = timeout_q;
    in_tol_prev_d  = in_tol_prev_q;

    unique case (state_q)
      StIdle: begin
        // First edge only starts the interval; nothing to report yet.
        if (edge_det) begin
          state_d = StMeasure;
          cnt_d   = '0;
        end
      end

      StMeasure: begin
        // Edge wins over a coincident timeout.
        if (edge_det) begin
          cnt_d          = '0;
          period_d       = meas[CNT_W-1:0];
          period_valid_d = 1'b1;
          locked_d       = in_tol & in_tol_prev_q;
          in_tol_prev_d  = in_tol;
        end else if (meas == TimeoutW) begin
          state_d       = StTimedOut;
          timeout_d     = 1'b1;
          locked_d      = 1'b0;
          in_tol_prev_d = 1'b0;
        end else begin
          cnt_d = meas[CNT_W-1:0];
        end
      end

      StTimedOut: begin
        // The interval ending at this edge started before activity resumed, so it
        // is not reported as a measurement.
        if (edge_det) begin
          state_d   = StMeasure;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q        <= StIdle;
      sync_q         <= '0;
      hist_q         <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
      in_tol_prev_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      hist_q         <= hist_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
      in_tol_prev_q  <= in_tol_prev_d;
    end
  end

  assign PERIOD       = period_q;
  assign PERIOD_VALID = period_valid_q;
  assign LOCKED       = locked_q;
  assign TIMEOUT_FLAG = timeout_q;
  assign LED          = {timeout_q, locked_q};

endmodule
